restoring_divider: RTL and testbench
====================================

# restoring_divider

Multi-cycle integer divider for the execute stage. It accepts one dividend/divisor pair per operation and produces quotient and remainder after a fixed number of cycles. Each cycle it performs one restoring-division step, using a trial subtraction built on the team's ripple `Adder`. Signed and unsigned modes match RISC-V M-extension semantics (DIV/DIVU/REM/REMU), including the divide-by-zero and overflow results.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width in bits (≥ 2).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  request a division; sampled only when not busy.
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned; captured with `start`.
- `dividend`  in  WIDTH  numerator; captured with `start`.
- `divisor`  in  WIDTH  denominator; captured with `start`.
- `busy`  out  1  high while an operation is iterating.
- `done`  out  1  one-cycle pulse; `quotient`/`remainder` valid this cycle.
- `quotient`  out  WIDTH  result quotient; held until next accepted `start`.
- `remainder`  out  WIDTH  result remainder; held until next accepted `start`.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE/DONE + `start`=1 → RUN, and operands are captured.
  - RUN with iteration counter = WIDTH-1 → DONE.
  - DONE without `start` → IDLE.
- Capture:
  - Signed mode: store |dividend| and |divisor| as unsigned magnitudes, plus `neg_q` = sign(dividend) XOR sign(divisor) and `neg_r` = sign(dividend).
  - Unsigned mode: `neg_q` = `neg_r` = 0.
- Datapath registers: partial remainder P (WIDTH+1 bits), quotient/shift register Q (WIDTH), divisor D (WIDTH), counter (clog2(WIDTH) bits).
- Each RUN cycle:
  - Form {P, Q} << 1.
  - Compute trial T = P_shifted − {0, D} as a (WIDTH+1)-bit add of ~D with `carry_in`=1.
  - If T is non-negative (MSB=0): P ← T, Q[0] ← 1. Otherwise P ← P_shifted, Q[0] ← 0.
- Finalise on entry to DONE:
  - `quotient` = `neg_q` ? −Q : Q.
  - `remainder` = `neg_r` ? −P[WIDTH-1:0] : P[WIDTH-1:0].
- Divide by zero (divisor = 0, either mode): `quotient` = all ones, `remainder` = original dividend. Latency is unchanged.
- Signed overflow (dividend = MIN, divisor = −1): the natural datapath result is `quotient` = MIN, `remainder` = 0. No special case is needed, but it must hold.
- The magnitude of MIN is 2^(WIDTH-1) and must be treated as unsigned throughout.

## Timing
- Reset: state IDLE; `busy`=0, `done`=0, `quotient`=0, `remainder`=0; counter and internal registers cleared.
- Latency: if `start` is accepted on edge T, then `busy`=1 for cycles T+1 … T+WIDTH, and `done`=1 with valid results in cycle T+WIDTH+1. This latency is fixed for all operand values.
- `start` while `busy`=1 is ignored; no queueing.
- `start` in the DONE cycle is accepted. The next operation begins back-to-back, and the current result is still presented for that one cycle.
- `rst` mid-operation aborts the operation: IDLE next cycle, and no `done` is emitted.
- Operand inputs may change freely after the capture edge.

## Structure
- Shared package `divider_pkg` holds:
  - state encoding constants `DIV_IDLE`, `DIV_RUN`, `DIV_DONE` (2 bits);
  - the `DIV_STEPS` helper (= WIDTH).
- One sub-module instance: `Adder` with WIDTH+1 bits, `b` = ~{0, D}, `carry_in`=1, for the trial subtraction.
- Sign conversion (negation) is plain combinational logic inside `restoring_divider`.

## Test plan
All scenarios use WIDTH=8.
- Unsigned 100 / 7, `start` at edge T → `busy` high cycles T+1…T+8; `done` at T+9 with `quotient`=14, `remainder`=2.
- Signed 0xF9 (−7) / 0x02 → `quotient`=0xFD (−3), `remainder`=0xFF (−1). Signed 7 / 0xFE (−2) → `quotient`=0xFD, `remainder`=0x01.
- 0x2A / 0x00 in both modes → `quotient`=0xFF, `remainder`=0x2A, `done` at T+9.
- Signed 0x80 / 0xFF → `quotient`=0x80, `remainder`=0x00. Unsigned 0x80 / 0xFF → `quotient`=0x00, `remainder`=0x80.
- Handshake:
  - `start` pulsed at T+3 during busy with different operands → ignored; the result matches the first operands.
  - `start` asserted in the `done` cycle → the second result arrives exactly 9 cycles later.
- `rst` asserted at T+4 → `busy`=0 and outputs 0 next cycle; `done` never pulses for the aborted operation; a fresh `start` afterwards completes correctly.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the multi-cycle restoring divider.
//   div_state_e : FSM state encoding (DIV_IDLE, DIV_RUN, DIV_DONE), 2 bits
//   DIV_STEPS   : number of restoring iterations for a given operand width
package divider_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // One quotient bit is produced per iteration.
  function automatic int unsigned DIV_STEPS(input int unsigned width);
    return width;
  endfunction

endpackage

// File: rtl/Adder.sv
// Ripple-carry adder used for the divider's trial subtraction.
//   a, b     : WIDTH-bit addends
//   carry_in : carry into bit 0
//   sum      : WIDTH-bit sum (carry out is not needed by the divider)
module Adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum
);

  // Bit-serial carry chain.
  always_comb begin : ripple
    logic c;
    c   = carry_in;
    sum = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring integer divider (RISC-V DIV/DIVU/REM/REMU semantics).
//   clk, rst   : clock, synchronous active-high reset
//   start      : request a division (sampled only when not busy)
//   is_signed  : 1 = two's-complement operands, captured with start
//   dividend   : numerator, captured with start
//   divisor    : denominator, captured with start
//   busy       : high while iterating
//   done       : one-cycle pulse, results valid
//   quotient   : result quotient, held until replaced
//   remainder  : result remainder, held until replaced
module restoring_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  import divider_pkg::*;

  localparam int unsigned STEPS = DIV_STEPS(WIDTH);
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  div_state_e       state;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;
  logic             trial_ok;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  // Operand magnitudes; |MIN| = 2^(WIDTH-1) is representable as unsigned.
  assign dividend_mag = (is_signed & dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
  assign divisor_mag  = (is_signed & divisor[WIDTH-1])  ? (~divisor  + WIDTH'(1)) : divisor;

  // {P,Q} << 1; P[WIDTH] is always 0 after a step, so it simply shifts out.
  assign p_shift = {p[WIDTH-1:0], q[WIDTH-1]};

  // Trial subtraction P_shift - {0,D} as P_shift + ~{0,D} + 1.
  Adder #(
    .WIDTH(WIDTH + 1)
  ) u_adder (
    .a        (p_shift),
    .b        (~{1'b0, d}),
    .carry_in (1'b1),
    .sum      (trial)
  );

  assign trial_ok = ~trial[WIDTH];
  assign p_next   = trial_ok ? trial : p_shift;
  assign q_next   = {q[WIDTH-2:0], trial_ok};

  // Sign fix-up; divide-by-zero quotient is forced to all ones, while the
  // datapath already leaves the original dividend in the remainder.
  assign q_final = div_zero ? '1 : (neg_q ? (~q_next + WIDTH'(1)) : q_next);
  assign r_final = neg_r ? (~p_next[WIDTH-1:0] + WIDTH'(1)) : p_next[WIDTH-1:0];

  logic unused_p_msb;
  assign unused_p_msb = p[WIDTH];

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DIV_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      p         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        DIV_IDLE, DIV_DONE: begin
          if (start) begin
            state    <= DIV_RUN;
            busy     <= 1'b1;
            p        <= '0;
            q        <= dividend_mag;
            d        <= divisor_mag;
            cnt      <= '0;
            neg_q    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r    <= is_signed & dividend[WIDTH-1];
            div_zero <= (divisor == '0);
          end else begin
            state <= DIV_IDLE;
          end
        end
        DIV_RUN: begin
          p   <= p_next;
          q   <= q_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) begin
            state     <= DIV_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_final;
            remainder <= r_final;
          end
        end
        default: begin
          state <= DIV_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider at WIDTH=8.
module tb_restoring_divider;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  int n_checks = 0;
  int n_pass   = 0;

  restoring_divider #(
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic sgn);
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
  endtask

  // From the cycle where start is driven: capture edge, 8 busy cycles
  // (optionally pulsing a stray start at busy cycle 'inject'), then the
  // done-cycle checks. Returns while still in the done cycle.
  task automatic run_body(input string tag, input logic [7:0] exp_q,
                          input logic [7:0] exp_r, input int inject);
    int busy_cycles;
    busy_cycles = 0;
    step();
    start     = 1'b0;
    dividend  = 8'hA5;
    divisor   = 8'h3C;
    is_signed = ~is_signed;
    for (int i = 1; i <= 8; i++) begin
      if (i == inject) begin
        start     = 1'b1;
        dividend  = 8'h2A;
        divisor   = 8'h05;
        is_signed = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (busy === 1'b1 && done === 1'b0) busy_cycles++;
      step();
    end
    start = 1'b0;
    check({tag, " busy_cycles"}, 32'(busy_cycles), 32'd8);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " quotient"}, 32'(quotient), 32'(exp_q));
    check({tag, " remainder"}, 32'(remainder), 32'(exp_r));
  endtask

  task automatic div_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic sgn, input logic [7:0] exp_q, input logic [7:0] exp_r);
    launch(a, b, sgn);
    run_body(tag, exp_q, exp_r, 0);
    step();
    check({tag, " done_drops"}, 32'(done), 32'd0);
    check({tag, " q_held"}, 32'(quotient), 32'(exp_q));
  endtask

  initial begin
    int done_seen;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    step();
    step();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    rst = 1'b0;
    step();

    div_op("u100/7",   8'd100, 8'd7,   1'b0, 8'd14,  8'd2);
    div_op("s-7/2",    8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF);
    div_op("s7/-2",    8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01);
    div_op("u2A/0",    8'h2A,  8'h00,  1'b0, 8'hFF,  8'h2A);
    div_op("s2A/0",    8'h2A,  8'h00,  1'b1, 8'hFF,  8'h2A);
    div_op("sF0/0",    8'hF0,  8'h00,  1'b1, 8'hFF,  8'hF0);
    div_op("s80/-1",   8'h80,  8'hFF,  1'b1, 8'h80,  8'h00);
    div_op("u80/FF",   8'h80,  8'hFF,  1'b0, 8'h00,  8'h80);
    div_op("uFF/1",    8'hFF,  8'h01,  1'b0, 8'hFF,  8'h00);
    div_op("s-128/7",  8'h80,  8'h07,  1'b1, 8'hEE,  8'hFE);

    // Stray start during busy is ignored.
    launch(8'd100, 8'd7, 1'b0);
    run_body("ignore", 8'd14, 8'd2, 3);
    step();

    // Start in the done cycle: back-to-back, second result 9 cycles later.
    launch(8'd100, 8'd7, 1'b0);
    run_body("b2b_first", 8'd14, 8'd2, 0);
    launch(8'hF9, 8'h02, 1'b1);
    run_body("b2b_second", 8'hFD, 8'hFF, 0);
    step();

    // Reset mid-operation aborts with no done pulse.
    launch(8'd100, 8'd7, 1'b0);
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort quotient", 32'(quotient), 32'd0);
    check("abort remainder", 32'(remainder), 32'd0);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) done_seen++;
      step();
    end
    check("abort no_done", 32'(done_seen), 32'd0);
    div_op("after_abort", 8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
